bus_burst_reader: RTL and testbench

- Bus read master that sits directly upstream of the ROM bus slave wrapper.
- Accepts a read command (start address, beat count) and drives the ADDR_S/BLEN_S/RVALID_S bus request.
- Counts beats and increments the address itself, because the slave holds RLAST_S low.
- Buffers returned words in a small FIFO and presents them on a valid/ready stream to the compute datapath.

---
 rtl/bus_burst_reader.sv | 175 +++++++++++++++++
 tb/tb_bus_burst_reader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_burst_reader.sv
// bus_burst_reader
//   Read master for the ROM bus slave. It takes a (start address, beat count)
//   command, issues the beats one word at a time on the ADDR_S/BLEN_S/RVALID_S
//   request, and counts beats itself because the slave may never raise
//   RLAST_S. Returned words go through a small registered FIFO and leave on a
//   valid/ready stream, each tagged with an end-of-command flag.
//
// Ports
//   bus_clk, bus_rst            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_addr, cmd_len payload
//   ADDR_S, BLEN_S, RVALID_S    bus request (current beat address, burst len)
//   RDATA_S, RLAST_S, RREADY_S  slave response, same-cycle data
//   out_valid/out_ready         output stream; out_data, out_last payload
//   busy                        a command is in progress (not IDLE)
//   done                        one-cycle pulse after a command finishes

`ifndef BUS_ADDR_BITS
`define BUS_ADDR_BITS 16
`endif
`ifndef BUS_DATA_BITS
`define BUS_DATA_BITS 32
`endif
`ifndef BUS_LEN_BITS
`define BUS_LEN_BITS 8
`endif

module bus_burst_reader #(
    parameter int ADDR_W     = `BUS_ADDR_BITS,
    parameter int DATA_W     = `BUS_DATA_BITS,
    parameter int LEN_W      = `BUS_LEN_BITS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              bus_clk,
    input  logic              bus_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] ADDR_S,
    output logic [LEN_W-1:0]  BLEN_S,
    output logic              RVALID_S,
    input  logic [DATA_W-1:0] RDATA_S,
    input  logic              RLAST_S,
    input  logic              RREADY_S,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  blen_q, blen_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              rvalid_q, rvalid_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic              fifo_last_q [FIFO_DEPTH];

    logic beat;
    logic beat_last;
    logic pop;

    // rvalid_q is only ever set while in READ, so it alone qualifies a beat.
    assign beat      = rvalid_q & RREADY_S;
    assign beat_last = (beat_cnt_q == blen_q - LEN_W'(1)) | RLAST_S;
    assign pop       = (count_q != '0) & out_ready;

    // State and registered bus outputs
    always_ff @(posedge bus_clk or negedge bus_rst) begin
        if (!bus_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            blen_q     <= '0;
            beat_cnt_q <= '0;
            rvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            blen_q     <= blen_d;
            beat_cnt_q <= beat_cnt_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        blen_d     = blen_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        addr_d     = cmd_addr;
                        blen_d     = cmd_len;
                        beat_cnt_d = '0;
                        state_d    = READ;
                    end else begin
                        // Empty command: no bus traffic, just report completion.
                        state_d = FIN;
                    end
                end
            end
            READ: begin
                if (beat) begin
                    addr_d     = addr_q + ADDR_W'(1);
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    if (beat_last) state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping
    always_comb begin
        wr_ptr_d = beat ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(beat) - CNT_W'(pop);
    end

    always_ff @(posedge bus_clk or negedge bus_rst) begin
        if (!bus_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else if (beat) begin
            fifo_data_q[wr_ptr_q] <= RDATA_S;
            fifo_last_q[wr_ptr_q] <= beat_last;
        end
    end

    // Outputs
    always_comb begin
        // The request for the next cycle is based on the occupancy the FIFO
        // will have after this edge; a pop in that later cycle cannot
        // re-enable it, so a full FIFO can never be pushed.
        rvalid_d  = (state_d == READ) && (count_d < CNT_W'(FIFO_DEPTH));
        // done lags FIN by one cycle (two cycles after the handshake of an
        // empty command), landing in the cycle the block is back in IDLE.
        done_d    = (state_q == FIN);
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        ADDR_S    = addr_q;
        BLEN_S    = blen_q;
        RVALID_S  = rvalid_q;
        done      = done_q;
        out_valid = (count_q != '0);
        out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
        out_last  = out_valid ? fifo_last_q[rd_ptr_q] : 1'b0;
    end

endmodule

// File: tb/tb_bus_burst_reader.sv
// Scoreboard bench for bus_burst_reader. Each command pushes its expected bus
// addresses and output words (derived from the start address, length and the
// beat index at which the slave model raises RLAST_S) into queues; the monitor
// pops and compares whenever a bus beat or an output pop is observed.
module tb_bus_burst_reader;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 4;

    logic              bus_clk = 1'b0;
    logic              bus_rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [ADDR_W-1:0] ADDR_S;
    logic [LEN_W-1:0]  BLEN_S;
    logic              RVALID_S;
    logic [DATA_W-1:0] RDATA_S;
    logic              RLAST_S;
    logic              RREADY_S = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    bus_burst_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .bus_clk(bus_clk), .bus_rst(bus_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ADDR_S(ADDR_S), .BLEN_S(BLEN_S), .RVALID_S(RVALID_S),
        .RDATA_S(RDATA_S), .RLAST_S(RLAST_S), .RREADY_S(RREADY_S),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 bus_clk = ~bus_clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    word_t             exp_out[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [LEN_W-1:0]  exp_blen = '0;

    int total = 0;
    int bad   = 0;
    int cmd_cnt = 0;
    int done_cnt = 0;
    int beat_seen = 0;
    int occ = 0;
    logic done_prev = 1'b0;

    // Slave model: word at address a is a*3; RLAST_S on one chosen address.
    int rready_mode = 0;  // 0 always, 1 alternate, 2 mostly, 3 coin flip
    int out_mode    = 0;  // 0 stalled, 1 always ready, 2 random
    logic              rlast_en = 1'b0;
    logic [ADDR_W-1:0] rlast_addr = '0;

    always_comb begin
        RDATA_S = DATA_W'(ADDR_S) * DATA_W'(3);
        RLAST_S = rlast_en && (ADDR_S == rlast_addr);
    end

    always @(posedge bus_clk) begin
        #1;
        case (rready_mode)
            0:       RREADY_S = 1'b1;
            1:       RREADY_S = ~RREADY_S;
            2:       RREADY_S = ($urandom_range(0, 3) != 0);
            default: RREADY_S = 1'($urandom_range(0, 1));
        endcase
        case (out_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Monitor / scoreboard
    always @(negedge bus_clk) begin
        if (!bus_rst) begin
            occ       = 0;
            done_prev = 1'b0;
        end else begin
            if (RVALID_S && RREADY_S) begin
                beat_seen++;
                check("push_when_full", 64'(occ == DEPTH), 64'(0));
                if (exp_addr.size() == 0) fail("spurious_beat");
                else begin
                    check("ADDR_S", 64'(ADDR_S), 64'(exp_addr.pop_front()));
                    check("BLEN_S", 64'(BLEN_S), 64'(exp_blen));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) fail("spurious_out");
                else begin
                    word_t w;
                    w = exp_out.pop_front();
                    check("out_data", 64'(out_data), 64'(w.data));
                    check("out_last", 64'(out_last), 64'(w.last));
                end
            end
            occ = occ + int'(RVALID_S && RREADY_S) - int'(out_valid && out_ready);
            if (done) begin
                done_cnt++;
                check("done_one_cycle", 64'(done_prev), 64'(0));
            end
            done_prev = done;
        end
    end

    // Reference model: a command of len beats from addr, cut short at beat
    // index `early` when the slave raises RLAST_S there.
    task automatic issue(input logic [ADDR_W-1:0] a, input int len, input int early);
        int n;
        bit ok;
        n = (len == 0) ? 0 : ((early >= 0 && early < len) ? early + 1 : len);
        @(posedge bus_clk); #1;
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_len    = LEN_W'(len);
        rlast_en   = (early >= 0);
        rlast_addr = a + ADDR_W'(early);
        if (len != 0) exp_blen = LEN_W'(len);
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] wa;
            word_t w;
            wa = a + ADDR_W'(i);
            w.data = DATA_W'(wa) * DATA_W'(3);
            w.last = (i == n - 1);
            exp_addr.push_back(wa);
            exp_out.push_back(w);
        end
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge bus_clk);
            if (cmd_ready) ok = 1;
        end
        if (!ok) fail("cmd_ready_timeout");
        @(posedge bus_clk); #1;
        cmd_valid = 1'b0;
        cmd_cnt++;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge bus_clk); #1;
            if (done_cnt == cmd_cnt && exp_out.size() == 0 && exp_addr.size() == 0) ok = 1;
        end
        if (!ok) begin
            $display("FAIL completion_timeout: done=%0d cmds=%0d out_left=%0d", done_cnt,
                     cmd_cnt, exp_out.size());
            total++;
            bad++;
            exp_out.delete();
            exp_addr.delete();
            done_cnt = cmd_cnt;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        check({tag, "_RVALID_S"},  64'(RVALID_S),  64'(0));
        check({tag, "_ADDR_S"},    64'(ADDR_S),    64'(0));
        check({tag, "_BLEN_S"},    64'(BLEN_S),    64'(0));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out_data"},  64'(out_data),  64'(0));
        check({tag, "_out_last"},  64'(out_last),  64'(0));
        check({tag, "_busy"},      64'(busy),      64'(0));
        check({tag, "_done"},      64'(done),      64'(0));
    endtask

    initial begin
        int b0;
        bit ok;
        logic [ADDR_W-1:0] a;

        repeat (3) @(posedge bus_clk);
        @(negedge bus_clk);
        check_reset_outputs("rst");
        @(posedge bus_clk); #1;
        bus_rst = 1'b1;

        // Single burst, zero-wait slave
        rready_mode = 0; out_mode = 1;
        issue(16'h0010, 4, -1);
        for (int i = 0; i < 4; i++) begin
            @(negedge bus_clk);
            check("t1_beat",   64'(RVALID_S && RREADY_S), 64'(1));
            check("t1_ADDR_S", 64'(ADDR_S), 64'(16'h0010 + i));
        end
        wait_done();
        repeat (4) @(negedge bus_clk);
        check("t1_done_count", 64'(done_cnt), 64'(cmd_cnt));

        // Backpressure: only DEPTH beats fit while the consumer stalls
        out_mode = 0;
        b0 = beat_seen;
        issue(16'($urandom), 8, -1);
        repeat (12) @(negedge bus_clk);
        #1;
        check("t2_beats_stalled", 64'(beat_seen - b0), 64'(DEPTH));
        check("t2_RVALID_S",      64'(RVALID_S), 64'(0));
        check("t2_out_valid",     64'(out_valid), 64'(1));
        out_mode = 1;
        wait_done();
        check("t2_total_beats", 64'(beat_seen - b0), 64'(8));

        // Address wrap
        issue(16'hFFFE, 3, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge bus_clk);
            check("t3_ADDR_S", 64'(ADDR_S), 64'(16'(16'hFFFE + i)));
        end
        wait_done();

        // Zero length: done two cycles after the handshake, no bus traffic
        b0 = beat_seen;
        issue(16'h1234, 0, -1);
        @(negedge bus_clk);
        check("t4_done_c1",   64'(done), 64'(0));
        check("t4_busy_c1",   64'(busy), 64'(1));
        check("t4_RVALID_c1", 64'(RVALID_S), 64'(0));
        @(negedge bus_clk);
        check("t4_done_c2",   64'(done), 64'(1));
        check("t4_RVALID_c2", 64'(RVALID_S), 64'(0));
        @(negedge bus_clk);
        check("t4_done_c3",   64'(done), 64'(0));
        check("t4_out_valid", 64'(out_valid), 64'(0));
        wait_done();
        check("t4_no_beats", 64'(beat_seen - b0), 64'(0));

        // Early RLAST_S on beat 3 with alternating slave wait states
        rready_mode = 1;
        b0 = beat_seen;
        issue(16'h0200, 6, 2);
        wait_done();
        check("t5_beats", 64'(beat_seen - b0), 64'(3));
        check("t5_idle",  64'(busy), 64'(0));
        rlast_en = 1'b0;

        // Reset in the middle of a 5-beat burst
        rready_mode = 0; out_mode = 0;
        b0 = beat_seen;
        issue(16'h0400, 5, -1);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge bus_clk); #1;
            if (beat_seen - b0 >= 2) ok = 1;
        end
        if (!ok) fail("t6_beat_timeout");
        @(posedge bus_clk); #2;
        bus_rst = 1'b0;
        #1;
        check_reset_outputs("t6");
        exp_out.delete();
        exp_addr.delete();
        cmd_cnt--;
        repeat (2) @(negedge bus_clk);
        @(posedge bus_clk); #1;
        bus_rst = 1'b1;
        out_mode = 1;
        issue(16'h0600, 2, -1);
        wait_done();

        // Randomized commands, slave wait states and consumer stalls
        for (int n = 0; n < 40; n++) begin
            rready_mode = 2 + int'($urandom_range(0, 1));
            out_mode    = 2;
            a = 16'($urandom);
            issue(a, int'($urandom_range(0, 10)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
            wait_done();
        end
        out_mode = 1;
        repeat (5) @(negedge bus_clk);
        #1;
        check("final_done_count", 64'(done_cnt), 64'(cmd_cnt));
        check("final_idle", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
